reservation_station_aged: RTL and testbench

RESERVATION_STATION_AGED -- requirements
Module: reservation_station_aged

---
 rtl/reservation_station_aged_pkg.sv | 15 +
 rtl/reservation_station_aged_age_picker.sv | 65 ++++++
 rtl/reservation_station_aged.sv | 187 ++++++++++++++++++
 tb/tb_reservation_station_aged.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_aged_pkg.sv
// Shared constants for the aged reservation station: tag conventions and CDB match helper.
// Tags are zero-extended to TAG_MAX_W before matching so one helper serves any ROB_W.
package reservation_station_aged_pkg;

  localparam int ROB_W_DEFAULT = 4;
  localparam int TAG_MAX_W     = 16;
  localparam logic [TAG_MAX_W-1:0] TAG_NONE = '0;

  // Tag 0 means "value present", so it never matches a broadcast.
  function automatic logic cdb_match(input logic [TAG_MAX_W-1:0] q,
                                     input logic [TAG_MAX_W-1:0] tag);
    return (q != TAG_NONE) && (q == tag);
  endfunction

endpackage

// File: rtl/reservation_station_aged_age_picker.sv
// Age matrix picker: age_q[i][j] = 1 means entry i was allocated before entry j.
// Picks the single oldest entry among the ready vector.
module rs_age_picker #(
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             clear_i,
  input  logic [DEPTH-1:0] ready_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  output logic [DEPTH-1:0] oldest_o,
  output logic             any_o
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_i[i]) begin
        age_d[i] = '0;
      end else begin
        age_d[i] = age_d[i];
      end
    end
    // A new entry is younger than every other slot.
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc_i[k]) begin
        age_d[k] = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (i != k) begin
            age_d[i][k] = 1'b1;
          end else begin
            age_d[i][k] = 1'b0;
          end
        end
      end else begin
        age_d[k] = age_d[k];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clear_i) age_q[i] <= '0;
      else         age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    oldest_o = ready_i;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((i != j) && ready_i[j] && age_q[j][i]) begin
          oldest_o[i] = 1'b0;
        end else begin
          oldest_o[i] = oldest_o[i];
        end
      end
    end
    any_o = |ready_i;
  end

endmodule

// File: rtl/reservation_station_aged.sv
// Reservation station with CDB snooping, same-cycle insert bypass and oldest-ready issue
// into a single registered output stage.
module reservation_station_aged
  import reservation_station_aged_pkg::*;
#(
  parameter int RS_DEPTH  = 8,
  parameter int CDB_PORTS = 2,
  parameter int ROB_W     = ROB_W_DEFAULT,
  parameter int VAL_W     = 32,
  parameter int PAYLOAD_W = 67,
  localparam int OCC_W    = $clog2(RS_DEPTH + 1)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  input  logic [VAL_W-1:0]           in_Vj,
  input  logic [VAL_W-1:0]           in_Vk,
  input  logic [ROB_W-1:0]           in_Qj,
  input  logic [ROB_W-1:0]           in_Qk,
  input  logic [ROB_W-1:0]           in_dest,
  input  logic [CDB_PORTS*ROB_W-1:0] cdb_rob_id,
  input  logic [CDB_PORTS*VAL_W-1:0] cdb_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [VAL_W-1:0]           out_Vj,
  output logic [VAL_W-1:0]           out_Vk,
  output logic [ROB_W-1:0]           out_dest,
  output logic [OCC_W-1:0]           occupancy,
  output logic                       has_no_vacancy,
  output logic                       has_one_vacancy
);

  logic [RS_DEPTH-1:0]  busy_q, busy_d;
  logic [PAYLOAD_W-1:0] payload_q [RS_DEPTH], payload_d [RS_DEPTH];
  logic [VAL_W-1:0]     vj_q [RS_DEPTH], vj_d [RS_DEPTH];
  logic [VAL_W-1:0]     vk_q [RS_DEPTH], vk_d [RS_DEPTH];
  logic [ROB_W-1:0]     qj_q [RS_DEPTH], qj_d [RS_DEPTH];
  logic [ROB_W-1:0]     qk_q [RS_DEPTH], qk_d [RS_DEPTH];
  logic [ROB_W-1:0]     dest_q [RS_DEPTH], dest_d [RS_DEPTH];
  logic [OCC_W-1:0]     occ_q, occ_d;

  logic                 out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [VAL_W-1:0]     out_vj_q, out_vj_d, out_vk_q, out_vk_d;
  logic [ROB_W-1:0]     out_dest_q, out_dest_d;

  logic [ROB_W-1:0]     cdb_tag_s [CDB_PORTS];
  logic [VAL_W-1:0]     cdb_val_s [CDB_PORTS];
  logic                 clear_s, insert_s, issue_s, alloc_found_s, any_ready_s;
  logic [RS_DEPTH-1:0]  alloc_oh_s, alloc_s, free_s, ready_s, oldest_s;

  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_tag_s[p] = cdb_rob_id[p*ROB_W +: ROB_W];
      cdb_val_s[p] = cdb_value[p*VAL_W +: VAL_W];
    end
  end

  assign clear_s  = rst_in || flush_in;
  assign in_ready = (occ_q < OCC_W'(RS_DEPTH));
  assign insert_s = in_valid && in_ready;
  assign issue_s  = (!out_valid_q || out_ready) && any_ready_s;
  assign alloc_s  = insert_s ? alloc_oh_s : '0;
  assign free_s   = issue_s ? oldest_s : '0;

  always_comb begin
    alloc_oh_s    = '0;
    alloc_found_s = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy_q[i] && !alloc_found_s) begin
        alloc_oh_s[i] = 1'b1;
        alloc_found_s = 1'b1;
      end else begin
        alloc_oh_s[i] = alloc_oh_s[i];
      end
      ready_s[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  rs_age_picker #(.DEPTH(RS_DEPTH)) u_age_picker (
    .clk_in   (clk_in),
    .clear_i  (clear_s),
    .ready_i  (ready_s),
    .alloc_i  (alloc_s),
    .free_i   (free_s),
    .oldest_o (oldest_s),
    .any_o    (any_ready_s)
  );

  // Ports are scanned high-to-low so the lowest-index matching port is applied last.
  always_comb begin
    busy_d = busy_q; payload_d = payload_q; dest_d = dest_q;
    vj_d = vj_q; vk_d = vk_q; qj_d = qj_q; qk_d = qk_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (busy_q[i] && cdb_match(TAG_MAX_W'(qj_q[i]), TAG_MAX_W'(cdb_tag_s[p]))) begin
          vj_d[i] = cdb_val_s[p];
          qj_d[i] = '0;
        end else begin
          vj_d[i] = vj_d[i];
        end
        if (busy_q[i] && cdb_match(TAG_MAX_W'(qk_q[i]), TAG_MAX_W'(cdb_tag_s[p]))) begin
          vk_d[i] = cdb_val_s[p];
          qk_d[i] = '0;
        end else begin
          vk_d[i] = vk_d[i];
        end
      end
      if (free_s[i]) begin
        busy_d[i] = 1'b0;
      end else if (alloc_s[i]) begin
        busy_d[i] = 1'b1; payload_d[i] = in_payload; dest_d[i] = in_dest;
        vj_d[i] = in_Vj; qj_d[i] = in_Qj; vk_d[i] = in_Vk; qk_d[i] = in_Qk;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
          if (cdb_match(TAG_MAX_W'(in_Qj), TAG_MAX_W'(cdb_tag_s[p]))) begin
            vj_d[i] = cdb_val_s[p];
            qj_d[i] = '0;
          end else begin
            vj_d[i] = vj_d[i];
          end
          if (cdb_match(TAG_MAX_W'(in_Qk), TAG_MAX_W'(cdb_tag_s[p]))) begin
            vk_d[i] = cdb_val_s[p];
            qk_d[i] = '0;
          end else begin
            vk_d[i] = vk_d[i];
          end
        end
      end else begin
        busy_d[i] = busy_d[i];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q; out_payload_d = out_payload_q;
    out_vj_d = out_vj_q; out_vk_d = out_vk_q; out_dest_d = out_dest_q;
    if (issue_s) begin
      out_valid_d = 1'b1; out_payload_d = '0; out_vj_d = '0; out_vk_d = '0; out_dest_d = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (oldest_s[i]) begin
          out_payload_d = payload_q[i]; out_vj_d = vj_q[i];
          out_vk_d = vk_q[i]; out_dest_d = dest_q[i];
        end else begin
          out_dest_d = out_dest_d;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0; out_payload_d = '0; out_vj_d = '0; out_vk_d = '0; out_dest_d = '0;
    end else begin
      out_valid_d = out_valid_q;
    end
    occ_d = clear_s ? '0 : (occ_q + OCC_W'(insert_s) - OCC_W'(issue_s));
  end

  always_ff @(posedge clk_in) begin
    if (clear_s) begin
      busy_q <= '0; occ_q <= '0; out_valid_q <= 1'b0; out_payload_q <= '0;
      out_vj_q <= '0; out_vk_q <= '0; out_dest_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        payload_q[i] <= '0; dest_q[i] <= '0; vj_q[i] <= '0;
        vk_q[i] <= '0; qj_q[i] <= '0; qk_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d; occ_q <= occ_d; out_valid_q <= out_valid_d;
      out_payload_q <= out_payload_d; out_vj_q <= out_vj_d;
      out_vk_q <= out_vk_d; out_dest_q <= out_dest_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        payload_q[i] <= payload_d[i]; dest_q[i] <= dest_d[i]; vj_q[i] <= vj_d[i];
        vk_q[i] <= vk_d[i]; qj_q[i] <= qj_d[i]; qk_q[i] <= qk_d[i];
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_payload     = out_payload_q;
  assign out_Vj          = out_vj_q;
  assign out_Vk          = out_vk_q;
  assign out_dest        = out_dest_q;
  assign occupancy       = occ_q;
  assign has_no_vacancy  = (occ_d == OCC_W'(RS_DEPTH));
  assign has_one_vacancy = (occ_d == OCC_W'(RS_DEPTH - 1));

endmodule

// File: tb/tb_reservation_station_aged.sv
// Scoreboard bench for reservation_station_aged: expected issues are queued as stimulus is
// driven and compared, in order, whenever the output handshake completes.
module tb_reservation_station_aged;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [66:0] payload;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, in_valid, in_ready, out_valid, out_ready;
  logic [66:0] in_payload, out_payload;
  logic [31:0] in_Vj, in_Vk, out_Vj, out_Vk;
  logic [3:0]  in_Qj, in_Qk, in_dest, out_dest, occupancy;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        has_no_vacancy, has_one_vacancy;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  reservation_station_aged dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_Vj(in_Vj), .in_Vk(in_Vk), .in_Qj(in_Qj), .in_Qk(in_Qk), .in_dest(in_dest),
    .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_Vj(out_Vj), .out_Vk(out_Vk), .out_dest(out_dest),
    .occupancy(occupancy), .has_no_vacancy(has_no_vacancy), .has_one_vacancy(has_one_vacancy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] pay_of(input logic [3:0] dest);
    return {3'b101, 32'hC0DE_0000, 28'h0, dest};
  endfunction

  // Scoreboard monitor: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk_in) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_issue", {124'h0, out_dest}, 128'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("sb_dest", out_dest, e.dest);
        check_val("sb_vj", out_Vj, e.vj);
        check_val("sb_vk", out_Vk, e.vk);
        check_val("sb_payload", out_payload, e.payload);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] dest, input logic [31:0] vj, input logic [31:0] vk);
    exp_t e;
    e.dest = dest; e.vj = vj; e.vk = vk; e.payload = pay_of(dest);
    exp_q.push_back(e);
  endtask

  task automatic ins(input logic [3:0] dest, input logic [3:0] qj, input logic [3:0] qk,
                     input logic [31:0] vj, input logic [31:0] vk);
    in_valid = 1'b1; in_dest = dest; in_Qj = qj; in_Qk = qk;
    in_Vj = vj; in_Vk = vk; in_payload = pay_of(dest);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cdb(input logic [7:0] tags, input logic [63:0] vals);
    cdb_rob_id = tags; cdb_value = vals;
    tick();
    cdb_rob_id = '0; cdb_value = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    tick();
    check_val(tag, exp_q.size(), 0);
    check_val({tag, "_idle"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_payload = '0; in_Vj = '0; in_Vk = '0; in_Qj = '0; in_Qk = '0; in_dest = '0;
    cdb_rob_id = '0; cdb_value = '0;
    tick(); tick();
    rst_in = 1'b0;
    check_val("rst_occ", occupancy, 0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_dest", out_dest, 0);
    check_val("rst_no_vac", has_no_vacancy, 1'b0);

    // Basic latency: ready at insert, visible on the second edge.
    out_ready = 1'b1;
    push_exp(4'd3, 32'h11, 32'h22);
    ins(4'd3, 4'd0, 4'd0, 32'h11, 32'h22);
    check_val("lat_edge1_valid", out_valid, 1'b0);
    check_val("lat_edge1_occ", occupancy, 1);
    tick();
    check_val("lat_edge2_valid", out_valid, 1'b1);
    check_val("lat_edge2_dest", out_dest, 3);
    check_val("lat_edge2_occ", occupancy, 0);
    wait_drain("basic_drain");

    // Younger ready entry overtakes an older waiting one.
    ins(4'd1, 4'd5, 4'd0, 32'h0, 32'h2);
    push_exp(4'd2, 32'h3, 32'h4);
    ins(4'd2, 4'd0, 4'd0, 32'h3, 32'h4);
    push_exp(4'd1, 32'h10, 32'h2);
    cdb({4'd0, 4'd5}, {32'h0, 32'h10});
    wait_drain("wakeup_drain");

    // Same wakeup for two entries: oldest first.
    ins(4'd1, 4'd0, 4'd7, 32'h5, 32'h0);
    ins(4'd2, 4'd0, 4'd7, 32'h6, 32'h0);
    push_exp(4'd1, 32'h5, 32'hFF);
    push_exp(4'd2, 32'h6, 32'hFF);
    cdb({4'd7, 4'd0}, {32'hFF, 32'h0});
    wait_drain("age_drain");

    // Duplicate tag on both ports: port 0 wins.
    ins(4'd4, 4'd9, 4'd0, 32'h0, 32'h44);
    push_exp(4'd4, 32'hAA, 32'h44);
    cdb({4'd9, 4'd9}, {32'hBB, 32'hAA});
    wait_drain("dup_tag_drain");

    // Insert-cycle bypass.
    cdb_rob_id = {4'd0, 4'd4}; cdb_value = {32'h0, 32'hABCD};
    push_exp(4'd5, 32'hABCD, 32'h9);
    ins(4'd5, 4'd4, 4'd0, 32'h0, 32'h9);
    cdb_rob_id = '0; cdb_value = '0;
    tick();
    check_val("bypass_valid", out_valid, 1'b1);
    wait_drain("bypass_drain");

    // Fill to capacity with the output stalled; the first entry sits in the output stage.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_exp(4'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i));
      ins(4'(i + 1), 4'd0, 4'd0, 32'h100 + 32'(i), 32'h200 + 32'(i));
    end
    check_val("full_occ", occupancy, 8);
    check_val("full_in_ready", in_ready, 1'b0);
    check_val("full_no_vac", has_no_vacancy, 1'b1);
    check_val("full_one_vac", has_one_vacancy, 1'b0);
    check_val("full_out_dest", out_dest, 1);
    ins(4'd15, 4'd0, 4'd0, 32'hDEAD, 32'hBEEF);
    check_val("extra_occ", occupancy, 8);
    check_val("stall_out_dest", out_dest, 1);
    check_val("stall_out_vj", out_Vj, 32'h100);
    out_ready = 1'b1;
    #1;
    check_val("drain_one_vac", has_one_vacancy, 1'b1);
    wait_drain("full_drain");

    // Flush with work in flight overrides a same-cycle insert.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) ins(4'(i + 8), 4'd0, 4'd0, 32'h300, 32'h400);
    check_val("pre_flush_occ", occupancy, 5);
    check_val("pre_flush_valid", out_valid, 1'b1);
    flush_in = 1'b1; in_valid = 1'b1; in_dest = 4'd14; in_Qj = '0; in_Qk = '0;
    tick();
    flush_in = 1'b0; in_valid = 1'b0;
    check_val("flush_occ", occupancy, 0);
    check_val("flush_valid", out_valid, 1'b0);
    check_val("flush_in_ready", in_ready, 1'b1);
    check_val("flush_out_dest", out_dest, 0);
    out_ready = 1'b1;
    tick(); tick();
    check_val("post_flush_valid", out_valid, 1'b0);
    check_val("post_flush_occ", occupancy, 0);

    check_val("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
